// File: rtl/mem_stage.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access stage of the 16-bit pipeline. It sits between the
//             EX/MEM and MEM/WB pipeline registers, issues loads/stores over a
//             req/ack handshake, stalls upstream until the access completes,
//             and forwards the writeback control/data set to MEM/WB. A bubble
//             is emitted on every stall cycle.
//  Ports    : clk, rst_n (sync, active low)
//             EX/MEM side : valid_in, MemRead_in, MemWrite_in, RegWrite_in,
//                           ret_in, mem_to_reg_in, HALT_in, reg_rd_in,
//                           alu_result_in, store_data_in
//             Pipeline    : stall_out
//             Memory side : mem_req, mem_we, mem_addr, mem_wdata,
//                           mem_rdata, mem_ack, mem_err (sticky timeout)
//             MEM/WB side : RegWrite_out, ret_out, mem_to_reg_out, HALT_out,
//                           reg_rd_out, mem_read_data_out, alu_result_out
//             Perf        : stall_cycles, mem_ops
//  Config   : define MEM_STAGE_PERF_EN to build the saturating performance
//             counters; otherwise both counter ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int          TIMEOUT  = 64,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        ret_in,
    input  logic        mem_to_reg_in,
    input  logic        HALT_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] store_data_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err,
    output logic        RegWrite_out,
    output logic        ret_out,
    output logic        mem_to_reg_out,
    output logic        HALT_out,
    output logic [3:0]  reg_rd_out,
    output logic [15:0] mem_read_data_out,
    output logic [15:0] alu_result_out,
    output logic [15:0] stall_cycles,
    output logic [15:0] mem_ops
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last WAIT count value before the access is forced to complete.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_rdata;
    logic        r_err;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic w_live;
    logic w_stall;
    logic w_timeout;

    assign w_live    = valid_in && (MemRead_in || MemWrite_in);
    // Combinational so the upstream registers freeze in this same cycle.
    assign w_stall   = ((r_state == S_IDLE) && w_live) || (r_state == S_WAIT);
    assign w_timeout = (r_cnt == c_timeout_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_rdata <= 16'h0000;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_live) begin
                        // Both strobes high is a load, so write only if pure store.
                        r_we    <= MemWrite_in && !MemRead_in;
                        r_addr  <= alu_result_in;
                        r_wdata <= store_data_in;
                        r_cnt   <= 8'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // An ack arriving on the last allowed cycle still wins.
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_out = w_stall;
    assign mem_req   = (r_state == S_WAIT);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_err   = r_err;

    always_comb begin
        RegWrite_out      = RegWrite_in;
        ret_out           = ret_in;
        mem_to_reg_out    = mem_to_reg_in;
        HALT_out          = HALT_in;
        reg_rd_out        = reg_rd_in;
        alu_result_out    = alu_result_in;
        mem_read_data_out = 16'h0000;
        if (w_stall) begin
            RegWrite_out   = 1'b0;
            ret_out        = 1'b0;
            mem_to_reg_out = 1'b0;
            HALT_out       = 1'b0;
        end
        // Stores present zero read data even though r_rdata may hold ERR_DATA.
        if ((r_state == S_DONE) && !r_we) begin
            mem_read_data_out = r_rdata;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_mem_ops;
    logic        w_enter_done;

    assign w_enter_done = (r_state == S_WAIT) && (mem_ack || w_timeout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'h0000;
            r_mem_ops      <= 16'h0000;
        end else begin
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_enter_done && (r_mem_ops != 16'hFFFF)) begin
                r_mem_ops <= r_mem_ops + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign mem_ops      = r_mem_ops;
`else
    assign stall_cycles = 16'h0000;
    assign mem_ops      = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage (TIMEOUT = 8). Table of
//             single-cycle IDLE vectors, hand sequences for multi-cycle
//             accesses, timeout and reset-during-WAIT, then randomized
//             instructions against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int          T   = 8;
    localparam logic [15:0] ERR = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, MemRead_in, MemWrite_in;
    logic        RegWrite_in, ret_in, mem_to_reg_in, HALT_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result_in, store_data_in;
    logic        stall_out, mem_req, mem_we, mem_err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        RegWrite_out, ret_out, mem_to_reg_out, HALT_out;
    logic [3:0]  reg_rd_out;
    logic [15:0] mem_read_data_out, alu_result_out, stall_cycles, mem_ops;

    mem_stage #(.TIMEOUT(T), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .ret_in(ret_in),
        .mem_to_reg_in(mem_to_reg_in), .HALT_in(HALT_in),
        .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .stall_out(stall_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_err(mem_err), .RegWrite_out(RegWrite_out), .ret_out(ret_out),
        .mem_to_reg_out(mem_to_reg_out), .HALT_out(HALT_out),
        .reg_rd_out(reg_rd_out), .mem_read_data_out(mem_read_data_out),
        .alu_result_out(alu_result_out), .stall_cycles(stall_cycles),
        .mem_ops(mem_ops)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit exp_err;
    int exp_sc;
    int exp_ops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
        int sc_e, ops_e;
`ifdef MEM_STAGE_PERF_EN
        sc_e  = (exp_sc  > 65535) ? 65535 : exp_sc;
        ops_e = (exp_ops > 65535) ? 65535 : exp_ops;
`else
        sc_e  = 0;
        ops_e = 0;
`endif
        chk({tag, "_stall_cycles"}, {16'h0, stall_cycles}, sc_e);
        chk({tag, "_mem_ops"},      {16'h0, mem_ops},      ops_e);
    endtask

    task automatic drive(input logic v, input logic mr, input logic mw,
                         input logic [3:0] ctrl, input logic [3:0] rd,
                         input logic [15:0] alu, input logic [15:0] sd);
        valid_in      = v;
        MemRead_in    = mr;
        MemWrite_in   = mw;
        RegWrite_in   = ctrl[3];
        ret_in        = ctrl[2];
        mem_to_reg_in = ctrl[1];
        HALT_in       = ctrl[0];
        reg_rd_in     = rd;
        alu_result_in = alu;
        store_data_in = sd;
    endtask

    // Runs one instruction from IDLE until it leaves the stage. ack_at = n
    // acks on the n-th request cycle; 0 or > T means no ack (timeout).
    // Entered and left at posedge+1.
    task automatic run_instr(input string tag, input logic v, input logic mr, input logic mw,
                             input int ack_at, input logic [15:0] addr, input logic [15:0] wd,
                             input logic [15:0] rdat, input logic [3:0] ctrl, input logic [3:0] rd);
        bit   live, is_load, to, done, hold_bad, bubble_bad;
        logic exp_we;
        int   exp_stall, exp_reqs, nstall, reqs;
        logic [15:0] exp_rd;

        live      = v && (mr || mw);
        is_load   = mr;
        exp_we    = mw && !mr;
        to        = live && !(ack_at >= 1 && ack_at <= T);
        exp_stall = !live ? 0 : (to ? T + 1 : ack_at + 1);
        exp_reqs  = live ? exp_stall - 1 : 0;
        exp_rd    = (!live || !is_load) ? 16'h0000 : (to ? ERR : rdat);
        if (to) exp_err = 1'b1;
        exp_sc   += exp_stall;
        if (live) exp_ops++;

        drive(v, mr, mw, ctrl, rd, addr, wd);
        nstall = 0; reqs = 0; done = 0; hold_bad = 0; bubble_bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (mem_req) begin
                reqs++;
                if (mem_we !== exp_we || mem_addr !== addr || mem_wdata !== wd) hold_bad = 1;
                if (reqs == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdat;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'($urandom);
                end
            end else begin
                // stray acks outside WAIT must be ignored
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = 16'($urandom);
            end
            @(negedge clk);
            if (stall_out) begin
                nstall++;
                if ({RegWrite_out, ret_out, mem_to_reg_out, HALT_out} !== 4'b0000) bubble_bad = 1;
            end else begin
                done = 1;
                break;
            end
        end
        chk({tag, "_complete"}, {31'd0, done}, 1);
        chk({tag, "_stall_count"}, nstall, exp_stall);
        chk({tag, "_req_count"}, reqs, exp_reqs);
        chk({tag, "_req_hold"}, {31'd0, hold_bad}, 0);
        chk({tag, "_bubble"}, {31'd0, bubble_bad}, 0);
        chk({tag, "_req_low_done"}, {31'd0, mem_req}, 0);
        chk({tag, "_rdata"}, {16'h0, mem_read_data_out}, {16'h0, exp_rd});
        chk({tag, "_ctrl"}, {28'd0, RegWrite_out, ret_out, mem_to_reg_out, HALT_out}, {28'd0, ctrl});
        chk({tag, "_rd_alu"}, {12'd0, reg_rd_out, alu_result_out}, {12'd0, rd, addr});
        chk({tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, exp_err});
        chk_perf(tag);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    typedef struct {
        logic v, mr, mw;
        logic [3:0]  ctrl;
        logic [3:0]  rd;
        logic [15:0] alu;
        logic        exp_stall;
        logic [3:0]  exp_ctrl;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, ack;
        logic v;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b1000, 4'h3, 16'h1234, 1'b0, 4'b1000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'hF, 16'hFFFF, 1'b0, 4'b1111};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'b1010, 4'h5, 16'h0A0A, 1'b0, 4'b1010};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'h7, 16'h0040, 1'b1, 4'b0000};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 4'b0101, 4'h1, 16'h0010, 1'b1, 4'b0000};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 4'b1100, 4'h9, 16'h8000, 1'b1, 4'b0000};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'h0, 16'h0000, 1'b0, 4'b0000};

        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'h0, 16'h0000, 16'h0000);
        exp_err = 0; exp_sc = 0; exp_ops = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_mem_req", {31'd0, mem_req}, 0);
        chk("reset_mem_err", {31'd0, mem_err}, 0);
        chk("reset_stall", {31'd0, stall_out}, 0);
        chk("reset_addr_wdata", {mem_addr, mem_wdata}, 32'h0);
        chk_perf("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-cycle IDLE vectors; valid_in dropped before the edge so the
        // state never leaves IDLE.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].mr, tbl[i].mw, tbl[i].ctrl, tbl[i].rd, tbl[i].alu, 16'h5555);
            @(negedge clk);
            chk($sformatf("tbl%0d_stall", i), {31'd0, stall_out}, {31'd0, tbl[i].exp_stall});
            chk($sformatf("tbl%0d_ctrl", i),
                {28'd0, RegWrite_out, ret_out, mem_to_reg_out, HALT_out}, {28'd0, tbl[i].exp_ctrl});
            chk($sformatf("tbl%0d_req", i), {31'd0, mem_req}, 0);
            if (!tbl[i].exp_stall) begin
                chk($sformatf("tbl%0d_rd_alu", i), {12'd0, reg_rd_out, alu_result_out},
                    {12'd0, tbl[i].rd, tbl[i].alu});
                chk($sformatf("tbl%0d_rdata", i), {16'h0, mem_read_data_out}, 0);
            end
            #1;
            valid_in = 1'b0;
            @(posedge clk);
            #1;
        end

        // Directed multi-cycle sequences
        run_instr("alu", 1, 0, 0, 1, 16'h1234, 16'h0000, 16'h0000, 4'b1000, 4'h3);
        run_instr("load_ack1", 1, 1, 0, 1, 16'h0040, 16'h0000, 16'hBEEF, 4'b1010, 4'h2);
        run_instr("store_ack3", 1, 0, 1, 3, 16'h0010, 16'h00AA, 16'h1111, 4'b0000, 4'h0);
        run_instr("load_timeout", 1, 1, 0, 0, 16'h0080, 16'h0000, 16'h2222, 4'b1010, 4'h4);
        run_instr("after_timeout", 1, 0, 0, 0, 16'h0001, 16'h0000, 16'h0000, 4'b1000, 4'h5);

        // Reset during the 2nd WAIT cycle, followed by a late ack
        drive(1, 1, 0, 4'b1010, 4'h6, 16'h0020, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_wait_req", {31'd0, mem_req}, 1);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'h1111;
        exp_err = 0; exp_sc = 0; exp_ops = 0;
        @(negedge clk);
        chk("rst_req_low", {31'd0, mem_req}, 0);
        chk("rst_stall_low", {31'd0, stall_out}, 0);
        chk("rst_err_clear", {31'd0, mem_err}, 0);
        chk("rst_addr_clear", {16'h0, mem_addr}, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", {31'd0, mem_req}, 0);
        chk("late_ack_stall", {31'd0, stall_out}, 0);
        chk("late_ack_rdata", {16'h0, mem_read_data_out}, 0);
        chk_perf("rst_perf");
        @(posedge clk); #1;

        // Back-to-back single-wait loads
        run_instr("b2b_a", 1, 1, 0, 1, 16'h0100, 16'h0000, 16'hA5A5, 4'b1010, 4'h1);
        run_instr("b2b_b", 1, 1, 0, 1, 16'h0102, 16'h0000, 16'h5A5A, 4'b1010, 4'h2);
        chk_perf("b2b");

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            v    = ($urandom_range(0, 7) != 0);
            ack  = $urandom_range(0, 10);
            run_instr($sformatf("rnd%0d", i), v, (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                      ack, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

- Memory-access stage of the 16-bit pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues loads and stores to the data memory through a req/ack handshake and stalls the upstream pipeline until the access completes.
- Passes the writeback control and data set (RegWrite, ret, mem_to_reg, rd, read data, ALU result, HALT) to MEM/WB.
- Inserts a bubble on every stall cycle.

## Interface
Parameters:
- TIMEOUT, 64, max WAIT cycles before an access is force-completed as an error (1..255)
- ERR_DATA, 16'hDEAD, read data returned on a timed-out load

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  EX/MEM holds a live instruction
- MemRead_in  in  1  load
- MemWrite_in  in  1  store (MemRead_in and MemWrite_in both high: treated as load)
- RegWrite_in, ret_in, mem_to_reg_in, HALT_in  in  1 each  control passthrough
- reg_rd_in  in  4  destination register
- alu_result_in  in  16  ALU result / memory word address
- store_data_in  in  16  store data
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr, mem_wdata  out  16 each  request address and data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- mem_err  out  1  sticky timeout flag
- RegWrite_out, ret_out, mem_to_reg_out, HALT_out  out  1 each  to MEM/WB
- reg_rd_out  out  4  to MEM/WB
- mem_read_data_out, alu_result_out  out  16 each  to MEM/WB
- stall_cycles, mem_ops  out  16 each  performance counters (see Configuration)

## Operation
States: IDLE, WAIT, DONE.

IDLE:
- No live memory op (valid_in && (MemRead_in||MemWrite_in) false):
  - Outputs are combinational passthrough of the inputs.
  - mem_read_data_out = 0.
  - stall_out = 0.
  - The state does not change.
- Live memory op:
  - stall_out = 1.
  - Outputs are a bubble: RegWrite_out = ret_out = HALT_out = mem_to_reg_out = 0.
  - Latch mem_we, mem_addr = alu_result_in, mem_wdata = store_data_in.
  - Go to WAIT.

WAIT:
- mem_req = 1, with address, data and we held stable.
- stall_out = 1 and outputs are a bubble.
- An 8-bit counter increments each cycle.
- mem_ack = 1: capture mem_rdata into rdata_q and go to DONE.
- Counter reaches TIMEOUT-1 without ack: rdata_q = ERR_DATA, set mem_err, go to DONE.

DONE:
- mem_req = 0 and stall_out = 0.
- Outputs are passthrough of the inputs.
- mem_read_data_out = rdata_q for loads, 0 for stores.
- Next state is always IDLE. The upstream register advances at this edge, so a back-to-back memory op re-enters IDLE→WAIT.

Other rules:
- mem_ack outside WAIT is ignored.
- mem_err is cleared only by reset.
- ERR_DATA substitution applies to loads only; a timed-out store is dropped silently.

## Timing
Reset (rst_n low at a clk edge):
- State = IDLE, counter = 0, rdata_q = 0, mem_err = 0, mem_we/mem_addr/mem_wdata = 0.
- mem_req = 0 from the following cycle.
- Passthrough outputs follow the inputs combinationally (IDLE rules).
- Reset mid-WAIT abandons the access; a late ack is ignored.

Latency:
- Non-memory instruction: 0 added cycles.
- Memory op with ack in the first WAIT cycle: 2 stall cycles (IDLE, WAIT), result presented in DONE.
- Ack after k WAIT cycles: k+1 stall cycles.
- Timeout: TIMEOUT+1 stall cycles.

Handshake and stalls:
- mem_req never drops before ack or timeout.
- One outstanding request maximum.
- stall_out is combinational from state and inputs, so upstream registers see it in the same cycle.

## Configuration
Macro MEM_STAGE_PERF_EN:
- Defined:
  - stall_cycles increments every cycle stall_out = 1.
  - mem_ops increments on each transition into DONE.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: counter logic is absent and both ports are tied to 16'h0000.

## Test plan
- ALU op, valid_in = 1, RegWrite_in = 1, rd = 4'h3, alu_result_in = 16'h1234 -> same-cycle passthrough, stall_out = 0, mem_req never high.
- Load at addr 16'h0040, ack with mem_rdata = 16'hBEEF on the first WAIT cycle -> stall_out high for exactly 2 cycles; in DONE mem_read_data_out = 16'hBEEF, RegWrite_out = 1; MEM/WB captures it.
- Store addr 16'h0010, data 16'h00AA, ack after 3 WAIT cycles -> mem_we = 1 and stable addr/data for all 3 cycles, 4 stall cycles, bubble outputs during stall.
- Load with no ack, TIMEOUT = 8 -> mem_req high 8 cycles, mem_read_data_out = 16'hDEAD in DONE, mem_err = 1 and sticky.
- Reset asserted on the 2nd WAIT cycle, then ack pulsed -> state IDLE, mem_req low, ack ignored, mem_err = 0.
- With MEM_STAGE_PERF_EN, two back-to-back single-wait loads -> mem_ops = 2, stall_cycles = 4.
